// File: rtl/astro_pkg.sv
// Shared constants and the controller state type for the 80x80 block-search datapath.
// A search covers a 65x65 grid of candidate windows over a tile stored 20 words per row.
package astro_pkg;

    localparam int WIN_POS       = 65;
    localparam int WORDS_PER_ROW = 20;
    localparam int TOTAL_WIN     = 4225;

    localparam int CNT_W = 13;
    localparam int POS_W = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENABLE = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

endpackage

// File: rtl/min_tracker.sv
// Running minimum over a stream of window scores; the first score after a clear is taken
// unconditionally, later ones only when strictly smaller, so ties keep the earliest window.
module min_tracker
    import astro_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [15:0]      i_score,
    input  logic [POS_W-1:0] i_row,
    input  logic [POS_W-1:0] i_col,
    output logic [POS_W-1:0] o_best_row,
    output logic [POS_W-1:0] o_best_col,
    output logic [15:0]      o_best_score
);

    logic             r_first;
    logic [POS_W-1:0] r_best_row;
    logic [POS_W-1:0] r_best_col;
    logic [15:0]      r_best_score;
    logic             w_take;

    assign w_take = i_valid && (r_first || (i_score < r_best_score));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first      <= 1'b1;
            r_best_row   <= '0;
            r_best_col   <= '0;
            r_best_score <= 16'hFFFF;
        end else if (i_clear) begin
            r_first      <= 1'b1;
            r_best_row   <= '0;
            r_best_col   <= '0;
            r_best_score <= 16'hFFFF;
        end else if (w_take) begin
            r_first      <= 1'b0;
            r_best_row   <= i_row;
            r_best_col   <= i_col;
            r_best_score <= i_score;
        end
    end

    assign o_best_row   = r_best_row;
    assign o_best_col   = r_best_col;
    assign o_best_score = r_best_score;

endmodule

// File: rtl/search_controller.sv
// Sequences one full-tile search: enables the window handler, counts and ranks the SAD
// scores it returns, and reports the best window or flags an error on stall or stray data.
module search_controller
    import astro_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      frame_base,
    output logic [31:0]      mem_addr,
    output logic             wh_en,
    input  logic             wh_ack,
    input  logic [6:0]       wh_row,
    input  logic [6:0]       wh_col,
    input  logic             wh_window_ready,
    input  logic             wh_done,
    output logic             wh_receive,
    input  logic             score_valid,
    input  logic [15:0]      score,
    output logic [6:0]       best_row,
    output logic [6:0]       best_col,
    output logic [15:0]      best_score,
    output logic             result_valid,
    output logic             busy,
    output logic             error,
    output state_t           o_dbg_state
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_WIN);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIN_POS - 1);

    state_t           r_state;
    logic [31:0]      r_frame_base;
    logic [CNT_W-1:0] r_score_cnt;
    logic [POS_W-1:0] r_pos_row;
    logic [POS_W-1:0] r_pos_col;
    logic [WD_W-1:0]  r_wdog;
    logic             r_result_valid;
    logic             r_error;

    logic             w_active;
    logic             w_accept;
    logic             w_stray;
    logic             w_clear;
    logic             w_wd_expire;
    logic [CNT_W-1:0] w_count_nxt;

    // Handshake: the handler holds wh_en/wh_ack for one ENABLE exchange; after that each
    // score_valid cycle carries exactly one score, consumed in the same cycle (wh_receive).
    assign w_active    = (r_state == ENABLE) || (r_state == RUN) || (r_state == DRAIN);
    assign w_accept    = score_valid && w_active && (r_score_cnt != CNT_FULL);
    assign w_stray     = score_valid && !w_accept;
    assign w_clear     = (r_state == IDLE) && start;
    assign w_wd_expire = !score_valid && (r_wdog == WD_LAST);
    assign w_count_nxt = r_score_cnt + {{(CNT_W-1){1'b0}}, w_accept};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_frame_base   <= '0;
            r_score_cnt    <= '0;
            r_pos_row      <= '0;
            r_pos_col      <= '0;
            r_wdog         <= '0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;

            if (w_accept) begin
                r_score_cnt <= w_count_nxt;
                if (r_pos_col == POS_LAST) begin
                    r_pos_col <= '0;
                    r_pos_row <= (r_pos_row == POS_LAST) ? '0 : r_pos_row + 1'b1;
                end else begin
                    r_pos_col <= r_pos_col + 1'b1;
                end
            end

            if (w_stray) begin
                r_error <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    // A start in the same cycle as a stray score wins: error is cleared.
                    if (start) begin
                        r_frame_base <= frame_base;
                        r_score_cnt  <= '0;
                        r_pos_row    <= '0;
                        r_pos_col    <= '0;
                        r_wdog       <= '0;
                        r_error      <= 1'b0;
                        r_state      <= ENABLE;
                    end
                end
                ENABLE: begin
                    r_wdog <= '0;
                    if (wh_ack) begin
                        r_state <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (w_count_nxt == CNT_FULL) begin
                        r_state        <= REPORT;
                        r_result_valid <= 1'b1;
                    end else if (w_wd_expire) begin
                        r_error <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_wdog <= score_valid ? '0 : r_wdog + 1'b1;
                        if ((r_state == RUN) && wh_done) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                REPORT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    min_tracker u_min_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .i_valid      (w_accept),
        .i_score      (score),
        .i_row        (r_pos_row),
        .i_col        (r_pos_col),
        .o_best_row   (best_row),
        .o_best_col   (best_col),
        .o_best_score (best_score)
    );

    // wh_window_ready only paces the handler's own fetches; the controller needs no view of it.
    logic w_unused;
    assign w_unused = wh_window_ready;

    assign mem_addr     = r_frame_base + (32'(wh_row) * 32'(WORDS_PER_ROW)) + 32'(wh_col);
    assign wh_receive   = score_valid;
    assign wh_en        = (r_state == ENABLE);
    assign busy         = (r_state != IDLE);
    assign result_valid = r_result_valid;
    assign error        = r_error;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_search_controller.sv
// Randomized bench for search_controller: a window-handler driver feeds scores and a
// plain min-search over the score array predicts each reported best window.
module tb_search_controller;
    import astro_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] frame_base = '0;
    logic [31:0] mem_addr;
    logic        wh_en;
    logic        wh_ack = 1'b0;
    logic [6:0]  wh_row = '0;
    logic [6:0]  wh_col = '0;
    logic        wh_window_ready = 1'b0;
    logic        wh_done = 1'b0;
    logic        wh_receive;
    logic        score_valid = 1'b0;
    logic [15:0] score = '0;
    logic [6:0]  best_row;
    logic [6:0]  best_col;
    logic [15:0] best_score;
    logic        result_valid;
    logic        busy;
    logic        error;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    int scores [TOTAL_WIN];

    int          rv_count = 0;
    logic [6:0]  rv_row = '0;
    logic [6:0]  rv_col = '0;
    logic [15:0] rv_score = '0;

    int          last_row = 0;
    int          last_col = 0;
    int          last_score = 0;

    search_controller #(.TIMEOUT(255)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .frame_base      (frame_base),
        .mem_addr        (mem_addr),
        .wh_en           (wh_en),
        .wh_ack          (wh_ack),
        .wh_row          (wh_row),
        .wh_col          (wh_col),
        .wh_window_ready (wh_window_ready),
        .wh_done         (wh_done),
        .wh_receive      (wh_receive),
        .score_valid     (score_valid),
        .score           (score),
        .best_row        (best_row),
        .best_col        (best_col),
        .best_score      (best_score),
        .result_valid    (result_valid),
        .busy            (busy),
        .error           (error),
        .o_dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (result_valid) begin
            rv_count = rv_count + 1;
            rv_row   = best_row;
            rv_col   = best_col;
            rv_score = best_score;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base);
        tick();
        start      = 1'b1;
        frame_base = base;
        tick();
        start      = 1'b0;
    endtask

    task automatic handshake(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wh_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wh_en_wait: got wh_en=%0b expected 1 within 20 cycles", wh_en);
        end else begin
            tick();
            wh_ack = 1'b1;
            tick();
            wh_ack = 1'b0;
        end
    endtask

    task automatic feed(input int n, input int done_idx);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) tick();
            end
            score_valid = 1'b1;
            score       = 16'(scores[i]);
            wh_done     = (i == done_idx);
            if ((i % 512) == 0) begin
                @(negedge clk);
                checks++;
                if (wh_receive !== 1'b1) begin
                    errors++;
                    $display("FAIL wh_receive: got %0b expected 1 at window %0d", wh_receive, i);
                end
            end
            tick();
            score_valid = 1'b0;
            wh_done     = 1'b0;
        end
    endtask

    function automatic int model_idx(input int n);
        int best = 0;
        for (int i = 1; i < n; i++) begin
            if (scores[i] < scores[best]) best = i;
        end
        return best;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || error !== 1'b0 || wh_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%0b rv=%0b err=%0b en=%0b expected 0000",
                     busy, result_valid, error, wh_en);
        end
        checks++;
        if (best_score !== 16'hFFFF || best_row !== 7'd0 || best_col !== 7'd0) begin
            errors++;
            $display("FAIL reset_best: got %0d/%0d/%h expected 0/0/ffff", best_row, best_col, best_score);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
        wh_row = 7'd2;
        wh_col = 7'd1;
        #1;
        checks++;
        if (mem_addr !== 32'd41) begin
            errors++;
            $display("FAIL reset_mem_addr: got %h expected %h", mem_addr, 32'd41);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mem_addr();
        logic [31:0] exp_addr;
        do_start(32'h0000_1000);
        wh_row = 7'd3;
        wh_col = 7'd5;
        @(negedge clk);
        checks++;
        if (mem_addr !== 32'h0000_1041) begin
            errors++;
            $display("FAIL mem_addr_basic: got %h expected %h", mem_addr, 32'h0000_1041);
        end
        checks++;
        if (busy !== 1'b1 || wh_en !== 1'b1) begin
            errors++;
            $display("FAIL enable_flags: got busy=%0b en=%0b expected 11", busy, wh_en);
        end
        for (int k = 0; k < 6; k++) begin
            wh_row = 7'($urandom_range(0, 64));
            wh_col = 7'($urandom_range(0, 64));
            exp_addr = 32'h0000_1000 + 32'(wh_row) * 20 + 32'(wh_col);
            #1;
            checks++;
            if (mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL mem_addr_rand: got %h expected %h", mem_addr, exp_addr);
            end
        end
        // A start while busy must neither restart nor re-latch the base.
        do_start(32'h8000_0000);
        wh_row = 7'd3;
        wh_col = 7'd5;
        @(negedge clk);
        checks++;
        if (mem_addr !== 32'h0000_1041) begin
            errors++;
            $display("FAIL start_while_busy_addr: got %h expected %h", mem_addr, 32'h0000_1041);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_while_busy: got busy=%0b expected 1", busy);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_run(input int pattern);
        bit ok;
        int base_cnt;
        int idx;
        int done_idx;
        done_idx = -1;
        for (int i = 0; i < TOTAL_WIN; i++) begin
            case (pattern)
                0:       scores[i] = 1000;
                1:       scores[i] = $urandom_range(6, 60000);
                2:       scores[i] = $urandom_range(0, 65535);
                default: scores[i] = 65535;
            endcase
        end
        if (pattern == 0) begin
            scores[2000] = 7;
            done_idx     = TOTAL_WIN - 1;
        end
        if (pattern == 1) begin
            scores[10]  = 5;
            scores[300] = 5;
            done_idx    = 3000;
        end
        idx        = model_idx(TOTAL_WIN);
        last_row   = idx / WIN_POS;
        last_col   = idx % WIN_POS;
        last_score = scores[idx];

        do_start($urandom);
        handshake(ok);
        base_cnt = rv_count;
        if (ok) begin
            feed(TOTAL_WIN, done_idx);
            repeat (4) @(negedge clk);
        end
        checks++;
        if (rv_count - base_cnt !== 1) begin
            errors++;
            $display("FAIL result_pulses[%0d]: got %0d expected 1", pattern, rv_count - base_cnt);
        end
        checks++;
        if (rv_row !== 7'(last_row) || rv_col !== 7'(last_col)) begin
            errors++;
            $display("FAIL best_pos[%0d]: got %0d,%0d expected %0d,%0d",
                     pattern, rv_row, rv_col, last_row, last_col);
        end
        checks++;
        if (rv_score !== 16'(last_score)) begin
            errors++;
            $display("FAIL best_score[%0d]: got %0d expected %0d", pattern, rv_score, last_score);
        end
        checks++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL post_run_flags[%0d]: got busy=%0b err=%0b expected 00", pattern, busy, error);
        end
        checks++;
        if (best_row !== 7'(last_row) || best_col !== 7'(last_col) || best_score !== 16'(last_score)) begin
            errors++;
            $display("FAIL best_hold[%0d]: got %0d,%0d,%0d expected %0d,%0d,%0d",
                     pattern, best_row, best_col, best_score, last_row, last_col, last_score);
        end
    endtask

    task automatic test_idle_score();
        int base_cnt;
        base_cnt = rv_count;
        tick();
        score_valid = 1'b1;
        score       = 16'd0;
        tick();
        score_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL idle_score_error: got %0b expected 1", error);
        end
        checks++;
        if (best_row !== 7'(last_row) || best_col !== 7'(last_col) || best_score !== 16'(last_score)) begin
            errors++;
            $display("FAIL idle_score_best: got %0d,%0d,%0d expected %0d,%0d,%0d",
                     best_row, best_col, best_score, last_row, last_col, last_score);
        end
        checks++;
        if (busy !== 1'b0 || rv_count - base_cnt !== 0) begin
            errors++;
            $display("FAIL idle_score_state: got busy=%0b pulses=%0d expected 0,0", busy, rv_count - base_cnt);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int base_cnt;
        int first_k;
        do_start($urandom);
        @(negedge clk);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_cleared_by_start: got %0b expected 0", error);
        end
        handshake(ok);
        if (ok) begin
            for (int i = 0; i <= 100; i++) scores[i] = $urandom_range(0, 65535);
            base_cnt = rv_count;
            feed(101, -1);
            first_k = -1;
            for (int k = 1; k <= 300; k++) begin
                @(negedge clk);
                if (k == 200) begin
                    checks++;
                    if (error !== 1'b0 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL timeout_early: got err=%0b busy=%0b expected 0,1 at cycle 200",
                                 error, busy);
                    end
                end
                if (first_k < 0 && error === 1'b1) first_k = k;
            end
            checks++;
            if (first_k < 250 || first_k > 262) begin
                errors++;
                $display("FAIL timeout_cycle: got %0d expected about 256", first_k);
            end
            checks++;
            if (busy !== 1'b0 || dbg_state !== IDLE || error !== 1'b1) begin
                errors++;
                $display("FAIL timeout_state: got busy=%0b state=%0d err=%0b expected 0,%0d,1",
                         busy, dbg_state, error, IDLE);
            end
            checks++;
            if (rv_count - base_cnt !== 0) begin
                errors++;
                $display("FAIL timeout_no_result: got %0d pulses expected 0", rv_count - base_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base_cnt;
        do_start($urandom);
        handshake(ok);
        base_cnt = rv_count;
        if (ok) begin
            for (int i = 0; i < 1500; i++) scores[i] = $urandom_range(0, 65535);
            feed(1500, -1);
        end
        rst_n  = 1'b0;
        wh_row = 7'd0;
        wh_col = 7'd0;
        #2;
        checks++;
        if (busy !== 1'b0 || best_score !== 16'hFFFF || dbg_state !== IDLE || wh_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%0b best=%h state=%0d en=%0b expected 0,ffff,%0d,0",
                     busy, best_score, dbg_state, wh_en, IDLE);
        end
        checks++;
        if (mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_base: got %h expected 0", mem_addr);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (rv_count - base_cnt !== 0 || busy !== 1'b0 || best_score !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_mid_after: got pulses=%0d busy=%0b best=%h expected 0,0,ffff",
                     rv_count - base_cnt, busy, best_score);
        end
    endtask

    initial begin
        test_reset();
        test_mem_addr();
        test_full_run(0);
        test_full_run(1);
        test_idle_score();
        test_timeout();
        test_reset_mid();
        test_full_run(2);
        test_full_run(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/search_controller.md
SEARCH_CONTROLLER -- requirements
Module: search_controller

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; every register is rising-edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, one-cycle request to begin one 80x80 search.
REQ-004 SHALL have port frame_base, input, 32, word address of the frame tile; sampled on accepted start.
REQ-005 SHALL have port mem_addr, output, 32, read word address to frame memory.
REQ-006 SHALL have ports wh_en output 1, wh_ack input 1, wh_row input 7, wh_col input 7, wh_window_ready input 1, wh_done input 1, wh_receive output 1: the window-handler link.
REQ-007 SHALL have ports score_valid input 1 and score input 16: SAD result per window, delivered in window order.
REQ-008 SHALL have outputs best_row 7, best_col 7, best_score 16, result_valid 1, busy 1, error 1.
REQ-009 SHALL define parameter TIMEOUT, default 255: maximum cycles allowed between scores.

Function
REQ-010 SHALL implement states IDLE, ENABLE, RUN, DRAIN and REPORT.
REQ-011 IDLE: on start, SHALL latch frame_base, clear the counters and the min tracker, clear error, and go to ENABLE; start in any other state SHALL be ignored.
REQ-012 ENABLE: wh_en SHALL be 1; on wh_ack=1 SHALL go to RUN the next cycle; wh_en SHALL be 0 in every other state.
REQ-013 mem_addr SHALL be combinational: latched frame_base + wh_row*20 + wh_col, in 32-bit unsigned arithmetic with no register.
REQ-014 wh_receive SHALL equal score_valid combinationally.
REQ-015 Each score_valid SHALL increment a 13-bit score counter (0..4225) and advance the position counters pos_col (0..64) and pos_row (0..64): pos_col wraps 64->0 and then increments pos_row.
REQ-016 The min tracker SHALL replace best_* when score < best_score (strict), or unconditionally for the first score; ties keep the earlier position.
REQ-017 wh_done in RUN SHALL go to DRAIN; a count of 4225 in RUN or DRAIN SHALL go to REPORT.
REQ-018 A score_valid in the same cycle as wh_done SHALL be counted before the transition.
REQ-019 REPORT: result_valid SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE; best_* SHALL hold until the next accepted start.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 A watchdog SHALL count cycles since the last score in RUN and DRAIN and reset on each score_valid; on reaching TIMEOUT it SHALL set error and go to IDLE without result_valid.
REQ-022 A score_valid in IDLE or REPORT, or beyond 4225, SHALL be ignored by the tracker and SHALL set error.
REQ-023 error SHALL be sticky until the next accepted start.

Reset
REQ-024 While rst_n=0, the block SHALL be in IDLE with every counter at 0, frame_base latch 0, and best_row/best_col 0, best_score 16'hFFFF, result_valid 0, busy 0, error 0, wh_en 0.
REQ-025 Asserting reset mid-search SHALL abandon the search immediately; no result_valid SHALL follow release of reset.

Structure
REQ-026 Package astro_pkg SHALL hold WIN_POS=65, WORDS_PER_ROW=20, TOTAL_WIN=4225 and the state enum type.
REQ-027 The min tracker (compare, best registers, first flag) SHALL be sub-module min_tracker; all other logic SHALL be flat.

Verification
REQ-028 Reset, then start with frame_base=0x1000 and wh_row=3, wh_col=5 -> mem_addr=0x1000+65=0x1041.
REQ-029 Full run with score = 1000 except 7 at window 2000 -> one result_valid pulse, best_row=30, best_col=50, best_score=7.
REQ-030 Equal minimum 5 at windows 10 and 300 -> best_row=0, best_col=10.
REQ-031 Scores stop after window 100 -> error=1 after 255 idle cycles, back in IDLE, no result_valid.
REQ-032 rst_n pulsed low at window 1500, then released -> IDLE, best_score=16'hFFFF, busy=0; a fresh start completes normally.
REQ-033 score_valid while in IDLE -> error=1 and best_* unchanged; start while busy -> ignored, and frame_base is not re-latched.
